// File: rtl/sum4_seq_ctrl_pkg.sv
// Package for the sum4 sequencer: state type and a small datapath helper.
package sum4_seq_ctrl_pkg;

    typedef logic [1:0] state_t;

    // Conditionally invert one nibble (B operand for subtraction).
    function automatic logic [3:0] cond_invert(input logic [3:0] nib, input logic inv);
        logic [3:0] res;
        if (inv) begin
            res = ~nib;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/sum4.sv
// sum4: 4-bit full adder slice.
// Ports:
//   sum   - 4-bit sum of a + b + c_in
//   carry - carry out of bit 3
//   a, b  - 4-bit addends
//   c_in  - carry in
module sum4 (
    output logic [3:0] sum,
    output logic       carry,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in
);

    logic [4:0] total_s;

    // Plain 5-bit add; the top bit is the slice carry.
    always_comb begin
        total_s = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
    end

    assign sum   = total_s[3:0];
    assign carry = total_s[4];

endmodule

// File: rtl/sum4_seq_defs.vh
// Shared constants for the sum4 sequencer.
// Included inside the body of sum4_seq_ctrl so the localparams are scoped
// to that module.
//   ST_IDLE / ST_RUN / ST_DONE : 2-bit FSM state encodings
//   NIBBLE_W                   : width of one adder slice
localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_RUN   = 2'd1;
localparam logic [1:0] ST_DONE  = 2'd2;
localparam int         NIBBLE_W = 4;

// File: rtl/sum4_seq_ctrl.sv
// sum4_seq_ctrl: multi-precision adder sequencer.
// Adds two WIDTH-bit operands (WIDTH = 4*NIBBLES) by running one sum4 slice
// per clock, LSB nibble first, holding the carry in a register between
// nibbles. sum/cout only change on entry to DONE, so the consumer never
// sees a partial result.
//
// Optional feature macro: SUM4_SEQ_SUB_EN adds input 'sub'; when captured
// high, B is inverted and nibble-0 carry-in forced to 1 (a - b, cout=1 means
// no borrow).
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   start - request, honoured only in IDLE or DONE
//   a, b  - operands, captured on accepted start
//   cin   - carry into nibble 0, captured on accepted start
//   sub   - (SUM4_SEQ_SUB_EN only) subtract select, captured on accepted start
//   sum   - WIDTH-bit result, valid from done until the next accepted start
//   cout  - carry out of the top nibble, same validity as sum
//   busy  - high while the sequencer is in RUN
//   done  - one-cycle pulse when sum/cout become valid
module sum4_seq_ctrl
    import sum4_seq_ctrl_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUM4_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    `include "sum4_seq_defs.vh"

    localparam int               IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t             state_r;
    state_t             state_nx_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   res_sh_r;
    logic [WIDTH-1:0]   res_nx_s;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               busy_r;
    logic               done_r;
    logic               accept_s;
    logic               last_s;
    logic               sub_s;
    logic [3:0]         b_nib_s;
    logic [3:0]         nib_sum_s;
    logic               nib_carry_s;

`ifdef SUM4_SEQ_SUB_EN
    logic               sub_r;
    assign sub_s = sub_r;
`else
    assign sub_s = 1'b0;
`endif

    assign b_nib_s = cond_invert(b_sh_r[NIBBLE_W-1:0], sub_s);

    sum4 u_sum4 (
        .sum   (nib_sum_s),
        .carry (nib_carry_s),
        .a     (a_sh_r[NIBBLE_W-1:0]),
        .b     (b_nib_s),
        .c_in  (carry_r)
    );

    // Result fills from the top so after NIBBLES shifts nibble 0 sits at the bottom.
    always_comb begin
        res_nx_s = (res_sh_r >> NIBBLE_W) | (WIDTH'(nib_sum_s) << (WIDTH - NIBBLE_W));
    end

    // Handshake decode and next-state selection.
    always_comb begin
        accept_s   = 1'b0;
        last_s     = 1'b0;
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == IDX_LAST) begin
                    last_s     = 1'b1;
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, shift registers, carry/index and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            idx_r    <= {IDX_W{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef SUM4_SEQ_SUB_EN
            sub_r    <= 1'b0;
`endif
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_RUN);
            done_r  <= (state_nx_s == ST_DONE);
            if (accept_s) begin
                a_sh_r <= a;
                b_sh_r <= b;
                idx_r  <= {IDX_W{1'b0}};
`ifdef SUM4_SEQ_SUB_EN
                sub_r   <= sub;
                carry_r <= sub ? 1'b1 : cin;
`else
                carry_r <= cin;
`endif
            end else if (state_r == ST_RUN) begin
                a_sh_r   <= a_sh_r >> NIBBLE_W;
                b_sh_r   <= b_sh_r >> NIBBLE_W;
                res_sh_r <= res_nx_s;
                carry_r  <= nib_carry_s;
                idx_r    <= idx_r + IDX_W'(1);
                // Publish only once the final nibble is in.
                if (last_s) begin
                    sum_r  <= res_nx_s;
                    cout_r <= nib_carry_s;
                end
            end
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
